// File: rtl/v2v_pkg.sv
// Shared types and width helpers for the vector-to-vector dot-product scheduler.
package v2v_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic int clog2(input int unsigned n);
    int          r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r++;
    end
    return r;
  endfunction

  // Accumulator is wide enough that DIMENSION full-scale products can never overflow.
  function automatic int acc_width(input int width, input int dim);
    return 2 * width + clog2(dim);
  endfunction

endpackage

// File: rtl/v2v_mac.sv
// Signed multiply-accumulate stage; clr dominates en.
module v2v_mac
  import v2v_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ACC_W = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [2*WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]   acc_q, acc_d;

  assign prod = a * b;

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + ACC_W'(prod);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/v2v_scheduler.sv
// Round-robin scheduler sharing one signed dot-product MAC between NREQ requesters.
module v2v_scheduler
  import v2v_pkg::*;
#(
  parameter int DIMENSION = 16,
  parameter int WIDTH     = 8,
  parameter int NREQ      = 4,
  parameter int ID_W      = clog2(NREQ),
  parameter int ACC_W     = acc_width(WIDTH, DIMENSION)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NREQ-1:0]                 req,
  input  logic [NREQ*DIMENSION*WIDTH-1:0] req_v1,
  input  logic [NREQ*DIMENSION*WIDTH-1:0] req_v2,
  output logic [NREQ-1:0]                 gnt,
  input  logic                            flush,
  output logic                            busy,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic signed [ACC_W-1:0]         res_data,
  output logic [ID_W-1:0]                 res_id
);

  localparam int CNT_W = (clog2(DIMENSION) < 1) ? 1 : clog2(DIMENSION);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ID_W-1:0]         rr_q, rr_d;
  logic [ID_W-1:0]         res_id_q, res_id_d;
  logic [ID_W-1:0]         win;
  int unsigned             idx;
  logic                    found, grant_fire, last_el;
  logic                    mac_clr, mac_en;
  logic signed [ACC_W-1:0] mac_acc;

  logic [WIDTH-1:0]        v1_all [NREQ][DIMENSION];
  logic [WIDTH-1:0]        v2_all [NREQ][DIMENSION];
  logic signed [WIDTH-1:0] v1_q   [DIMENSION];
  logic signed [WIDTH-1:0] v2_q   [DIMENSION];

  always_comb begin
    for (int unsigned r = 0; r < NREQ; r++) begin
      for (int unsigned i = 0; i < DIMENSION; i++) begin
        v1_all[r][i] = req_v1[(r*DIMENSION + i)*WIDTH +: WIDTH];
        v2_all[r][i] = req_v2[(r*DIMENSION + i)*WIDTH +: WIDTH];
      end
    end
  end

  // First asserted request at or after the rr pointer, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = (32'(rr_q) + i) % NREQ;
      if (!found && req[idx[ID_W-1:0]]) begin
        found = 1'b1;
        win   = idx[ID_W-1:0];
      end
    end
  end

  assign last_el    = (cnt_q == CNT_W'(DIMENSION - 1));
  // Reset gating keeps gnt low while rst is asserted even with req pending.
  assign grant_fire = rst && !flush && found &&
                      ((state_q == S_IDLE) || ((state_q == S_DONE) && res_ready));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (grant_fire) state_d = S_RUN;
      S_RUN:   if (last_el) state_d = S_DONE;
      S_DONE:  if (res_ready) state_d = grant_fire ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  always_comb begin
    gnt = '0;
    if (grant_fire) gnt[win] = 1'b1;
    busy      = (state_q == S_RUN) || (state_q == S_DONE);
    res_valid = (state_q == S_DONE);
    mac_clr   = flush || grant_fire;
    mac_en    = (state_q == S_RUN);
  end

  always_comb begin
    cnt_d    = cnt_q;
    rr_d     = rr_q;
    res_id_d = res_id_q;
    if (flush || grant_fire) begin
      cnt_d = '0;
    end else if (state_q == S_RUN) begin
      cnt_d = last_el ? '0 : cnt_q + 1'b1;
    end
    if (grant_fire) begin
      rr_d     = (32'(win) == NREQ - 1) ? '0 : win + 1'b1;
      res_id_d = win;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      rr_q     <= '0;
      res_id_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      rr_q     <= rr_d;
      res_id_q <= res_id_d;
    end
  end

  always_ff @(posedge clk) begin
    if (grant_fire) begin
      for (int unsigned i = 0; i < DIMENSION; i++) begin
        v1_q[i] <= v1_all[win][i];
        v2_q[i] <= v2_all[win][i];
      end
    end
  end

  v2v_mac #(
    .WIDTH (WIDTH),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (mac_clr),
    .en  (mac_en),
    .a   (v1_q[cnt_q]),
    .b   (v2_q[cnt_q]),
    .acc (mac_acc)
  );

  assign res_data = mac_acc;
  assign res_id   = res_id_q;

endmodule

// File: tb/tb_v2v_scheduler.sv
// Directed and randomized checks of v2v_scheduler against a transaction-level model.
module tb_v2v_scheduler;

  localparam int DIM = 16;
  localparam int W   = 8;
  localparam int NR  = 4;
  localparam int IDW = 2;
  localparam int AW  = 20;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NR-1:0]          req;
  logic [NR*DIM*W-1:0]    req_v1, req_v2;
  logic [NR-1:0]          gnt;
  logic                   flush;
  logic                   busy;
  logic                   res_valid;
  logic                   res_ready;
  logic signed [AW-1:0]   res_data;
  logic [IDW-1:0]         res_id;

  always #5 clk = ~clk;

  v2v_scheduler #(
    .DIMENSION (DIM),
    .WIDTH     (W),
    .NREQ      (NR),
    .ID_W      (IDW),
    .ACC_W     (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_v1    (req_v1),
    .req_v2    (req_v2),
    .gnt       (gnt),
    .flush     (flush),
    .busy      (busy),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id)
  );

  typedef struct {
    int id;
    int val;
    int t;
  } job_t;

  job_t q[$];
  int   m1 [NR][DIM];
  int   m2 [NR][DIM];
  int   rr_m, k, vectors, miscompares;
  int   last_gnt_id, last_gnt_k;
  bit   hold_req;

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int arb(input logic [NR-1:0] r);
    for (int i = 0; i < NR; i++) begin
      int c;
      c = (rr_m + i) % NR;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  function automatic int dot(input int w);
    int s;
    s = 0;
    for (int i = 0; i < DIM; i++) s += m1[w][i] * m2[w][i];
    return s;
  endfunction

  task automatic set_elem(input int r, input int i, input int a, input int b);
    m1[r][i] = a;
    m2[r][i] = b;
    req_v1[(r*DIM + i)*W +: W] = W'(a);
    req_v2[(r*DIM + i)*W +: W] = W'(b);
  endtask

  task automatic rand_vec(input int r);
    for (int i = 0; i < DIM; i++)
      set_elem(r, i, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
  endtask

  // Called one time unit after a rising edge; checks this cycle, then advances one cycle.
  task automatic cycle_step();
    logic [NR-1:0] eg;
    bit            ev, hs;
    int            w;
    #1;
    ev = (q.size() > 0) && (k >= q[0].t + DIM + 1);
    chk("res_valid", res_valid, ev);
    chk("busy", busy, q.size() > 0);
    if (ev) begin
      chk("res_data", res_data, q[0].val);
      chk("res_id", res_id, q[0].id);
    end
    hs = ev && res_ready && !flush;
    eg = '0;
    w  = arb(req);
    if (!flush && (w >= 0) && ((q.size() == 0) || hs)) eg[w] = 1'b1;
    chk("gnt", gnt, eg);
    if (flush) q.delete();
    else if (hs) void'(q.pop_front());
    if (eg != '0) begin
      q.push_back('{id: w, val: dot(w), t: k});
      rr_m        = (w + 1) % NR;
      last_gnt_id = w;
      last_gnt_k  = k;
    end
    @(posedge clk);
    #1;
    k++;
    if ((eg != '0) && !hold_req) req[w] = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n;
    n = 0;
    while (!res_valid && n < budget) begin
      cycle_step();
      n++;
    end
    chk(tag, res_valid, 1'b1);
  endtask

  task automatic wait_grant(input string tag, input int id, input int budget);
    int n;
    n = 0;
    while (!(last_gnt_k == k - 1 && last_gnt_id == id) && n < budget) begin
      cycle_step();
      n++;
    end
    chk(tag, (last_gnt_k == k - 1 && last_gnt_id == id), 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int tg;
    int order [5];
    int gk [5];
    int ng, n;

    vectors = 0; miscompares = 0; rr_m = 0; k = 0;
    last_gnt_id = -1; last_gnt_k = -10; hold_req = 1'b0;
    rst = 1'b0; req = '0; flush = 1'b0; res_ready = 1'b0;
    req_v1 = '0; req_v2 = '0;
    for (int r = 0; r < NR; r++)
      for (int i = 0; i < DIM; i++) set_elem(r, i, 0, 0);

    #3;
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_data", res_data, 0);
    chk("rst_id", res_id, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Small known dot product: 1*5+2*6+3*7+4*8 = 70, result DIM+1 cycles after grant.
    for (int i = 0; i < DIM; i++) set_elem(0, i, (i < 4) ? i + 1 : 0, (i < 4) ? i + 5 : 0);
    req = 4'b0001;
    res_ready = 1'b1;
    #1;
    chk("t1_gnt", gnt, 4'b0001);
    tg = k;
    cycle_step();
    wait_valid("t1_wait", 40);
    chk("t1_lat", k - tg, DIM + 1);
    chk("t1_data", res_data, 70);
    chk("t1_id", res_id, 0);
    cycle_step();

    // Full-scale extremes.
    for (int i = 0; i < DIM; i++) set_elem(2, i, -128, -128);
    req = 4'b0100;
    wait_valid("t2_pos_wait", 40);
    chk("t2_pos", res_data, 262144);
    cycle_step();
    for (int i = 0; i < DIM; i++) set_elem(3, i, -128, 127);
    req = 4'b1000;
    wait_valid("t2_neg_wait", 40);
    chk("t2_neg", res_data, -260096);
    cycle_step();

    // Constant full request set: strict rotation, back-to-back jobs.
    for (int r = 0; r < NR; r++) rand_vec(r);
    hold_req = 1'b1;
    req = 4'b1111;
    ng = 0;
    n = 0;
    while (ng < 5 && n < 200) begin
      cycle_step();
      n++;
      if (last_gnt_k == k - 1) begin
        order[ng] = last_gnt_id;
        gk[ng]    = last_gnt_k;
        ng++;
      end
    end
    chk("t3_count", ng, 5);
    for (int j = 0; j < 5; j++) chk("t3_order", order[j], j % NR);
    for (int j = 1; j < 5; j++) chk("t3_gap", gk[j] - gk[j-1], DIM + 1);

    // Flush at count 2 of requester 1's job.
    wait_grant("t5_wait", 1, 40);
    cycle_step();
    cycle_step();
    flush = 1'b1;
    cycle_step();
    flush = 1'b0;
    #1;
    chk("t5_valid", res_valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_gnt", gnt, 4'b0100);
    cycle_step();
    hold_req = 1'b0;
    req = '0;

    // Consumer stalls with another request pending.
    res_ready = 1'b0;
    wait_valid("t4_wait", 40);
    rand_vec(1);
    req = 4'b0010;
    for (int i = 0; i < 10; i++) cycle_step();
    res_ready = 1'b1;
    #1;
    chk("t4_gnt", gnt, 4'b0010);
    cycle_step();
    wait_valid("t4_wait2", 40);
    cycle_step();

    // Asynchronous reset in the middle of a job.
    rand_vec(0);
    req = 4'b0001;
    cycle_step();
    cycle_step();
    cycle_step();
    cycle_step();
    #4;
    rst = 1'b0;
    req = '0;
    #1;
    chk("t6_gnt", gnt, 0);
    chk("t6_busy", busy, 0);
    chk("t6_valid", res_valid, 0);
    chk("t6_data", res_data, 0);
    chk("t6_id", res_id, 0);
    q.delete();
    rr_m = 0;
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    k++;
    rand_vec(3);
    req = 4'b1000;
    #1;
    chk("t6_regnt", gnt, 4'b1000);
    cycle_step();
    wait_valid("t6_wait", 40);
    chk("t6_res_id", res_id, 3);
    cycle_step();

    // Random traffic with stalls, drops and occasional flushes.
    for (int c = 0; c < 700; c++) begin
      for (int r = 0; r < NR; r++) begin
        if (!req[r] && $urandom_range(0, 3) == 0) begin
          rand_vec(r);
          req[r] = 1'b1;
        end else if (req[r] && $urandom_range(0, 99) < 2) begin
          req[r] = 1'b0;
        end
      end
      res_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 99) < 3);
      cycle_step();
    end
    flush = 1'b0;
    req = '0;
    res_ready = 1'b1;
    n = 0;
    while (q.size() > 0 && n < 60) begin
      cycle_step();
      n++;
    end
    #1;
    chk("drain_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
